// File: rtl/sampfifo_stream.sv
// ---------------------------------------------------------------------------
// sampfifo_stream
//   Sample FIFO between the capture front end and the drain/packetiser.
//   The capture side never stalls: a push into a full FIFO is dropped and
//   counted in a saturating overflow counter. Storage is a synchronous-read
//   RAM of DEPTH = 2**ADDR_W entries plus a one-entry output register, so
//   the total capacity is DEPTH+1.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active high
//   clear        synchronous flush (pointers, rvalid, level, ovf_count)
//   wdata        sample to push
//   wavail       push strobe, one sample per cycle
//   rdata        head sample, valid while rvalid=1
//   rvalid       rdata holds an unconsumed sample
//   rready       consumer accepts rdata when rvalid & rready
//   level        samples held (RAM entries + rvalid), registered
//   full         RAM holds DEPTH entries; pushes are dropped
//   almost_full  level >= THRESH, registered alongside level
//   ovf_count    dropped pushes since reset/clear, saturating
// ---------------------------------------------------------------------------
module sampfifo_stream #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 13,
   parameter int THRESH = 4096,
   parameter int OVF_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                wavail,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   input  logic                rready,
   output logic [ADDR_W:0]     level,
   output logic                full,
   output logic                almost_full,
   output logic [OVF_W-1:0]    ovf_count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W+1:0] THRESH_L = (ADDR_W+2)'(THRESH);

   logic [DATA_W-1:0] mem [DEPTH];

   // Pointers carry one extra bit so full and empty stay distinguishable
   // across any number of wraps.
   logic [ADDR_W:0]     wptr_q, wptr_d;
   logic [ADDR_W:0]     rptr_q, rptr_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q;
   logic [ADDR_W:0]     level_q, level_d;
   logic                almost_full_q, almost_full_d;
   logic [OVF_W-1:0]    ovf_q, ovf_d;

   logic [ADDR_W:0]     mem_cnt, mem_cnt_d;
   logic                full_mem, empty_mem;
   logic                push, drop, fire;

   assign mem_cnt   = wptr_q - rptr_q;
   assign full_mem  = (mem_cnt == DEPTH_L);
   assign empty_mem = (mem_cnt == '0);

   // full is the start-of-cycle value: a same-cycle pop never makes room.
   assign push = wavail & ~full_mem & ~clear;
   assign drop = wavail &  full_mem & ~clear;
   // Refill the output register when it is empty or being consumed.
   assign fire = ~empty_mem & (~rvalid_q | rready) & ~clear;

   always_comb begin
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      rvalid_d      = rvalid_q;
      ovf_d         = ovf_q;
      if (clear) begin
         wptr_d   = '0;
         rptr_d   = '0;
         rvalid_d = 1'b0;
         ovf_d    = '0;
      end else begin
         if (push)
            wptr_d = wptr_q + 1'b1;
         if (fire) begin
            rptr_d   = rptr_q + 1'b1;
            rvalid_d = 1'b1;
         end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
         end
         if (drop && (ovf_q != {OVF_W{1'b1}}))
            ovf_d = ovf_q + 1'b1;
      end
      mem_cnt_d     = wptr_d - rptr_d;
      level_d       = mem_cnt_d + {{ADDR_W{1'b0}}, rvalid_d};
      almost_full_d = ({1'b0, level_d} >= THRESH_L);
   end

   // RAM write port; contents are deliberately not reset or cleared.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr_q[ADDR_W-1:0]] <= wdata;
   end

   // Read and write addresses never coincide: fetch needs mem_cnt > 0 and
   // push needs mem_cnt < DEPTH, so no read-during-write handling exists.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         level_q       <= '0;
         almost_full_q <= 1'b0;
         ovf_q         <= '0;
      end else begin
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         rvalid_q      <= rvalid_d;
         level_q       <= level_d;
         almost_full_q <= almost_full_d;
         ovf_q         <= ovf_d;
         if (fire)
            rdata_q <= mem[rptr_q[ADDR_W-1:0]];
      end
   end

   assign rdata       = rdata_q;
   assign rvalid      = rvalid_q;
   assign level       = level_q;
   assign full        = full_mem;
   assign almost_full = almost_full_q;
   assign ovf_count   = ovf_q;

endmodule
